// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator trip controller.
//   estado_t          : trip FSM states
//   DIR_SOBE/DIR_DESCE: encoding of the direcao output
//   *_DEF             : default building geometry and timing
package elevador_pkg;

    typedef enum logic [1:0] {
        PARADO       = 2'd0,
        SUBINDO      = 2'd1,
        DESCENDO     = 2'd2,
        PORTA_ABERTA = 2'd3
    } estado_t;

    localparam logic DIR_SOBE  = 1'b1;
    localparam logic DIR_DESCE = 1'b0;

    localparam int N_ANDARES_DEF = 16;
    localparam int W_ANDAR_DEF   = 4;
    localparam int ANDAR_RES_DEF = 6;
    localparam int T_VIAGEM_DEF  = 1;
    localparam int T_PORTA_DEF   = 4;

endpackage

// File: rtl/temporizador_porta.sv
// Door hold-open timer: loadable down-counter.
//   clock   : system clock, rising edge
//   clear   : synchronous active-high reset (counter to 0)
//   carga   : load T_PORTA (door just opened)
//   segura  : reload T_PORTA (hold request while the door is open)
//   expirou : counter is on its last cycle; the door may close on this edge
//             unless a hold is present
module temporizador_porta #(
    parameter int T_PORTA = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic carga,
    input  logic segura,
    output logic expirou
);

    localparam int W_CONT = $clog2(T_PORTA + 1);
    localparam logic [W_CONT-1:0] CONT_CARGA = W_CONT'(T_PORTA);
    localparam logic [W_CONT-1:0] CONT_UM    = W_CONT'(1);
    localparam logic [W_CONT-1:0] CONT_ZERO  = {W_CONT{1'b0}};

    logic [W_CONT-1:0] r_cont;

    // Down-counter: reload on open or hold, otherwise count towards zero
    always_ff @(posedge clock) begin
        if (clear) begin
            r_cont <= CONT_ZERO;
        end else if (carga || segura) begin
            r_cont <= CONT_CARGA;
        end else if (r_cont != CONT_ZERO) begin
            r_cont <= r_cont - CONT_UM;
        end else begin
            r_cont <= r_cont;
        end
    end

    // Closing on the edge where the count leaves 1 keeps the door open
    // exactly T_PORTA cycles after the last load.
    assign expirou = (r_cont <= CONT_UM);

endmodule

// File: rtl/escalonador_elevador.sv
// Central trip controller for a multi-floor elevator.
// Latches qualified calls, runs a SCAN policy, moves one floor every
// T_VIAGEM cycles, stops at pending floors and times the door.
//   clock, clear   : clock and synchronous active-high reset
//   botoes         : call buttons (level), one per floor
//   cartao_acesso  : residential pass, qualifies same-cycle presses >= ANDAR_RES
//   sensor/segurar : door presence sensor / hold button, keep the door open
//   pendentes      : latched calls (button LEDs)
//   andar_atual    : current floor
//   direcao        : 1 = up, 0 = down (last or active direction)
//   movendo        : cabin travelling
//   porta_aberta   : door open
//   chegou         : one-cycle pulse when the cabin stops at a served floor
module escalonador_elevador
    import elevador_pkg::*;
#(
    parameter int N_ANDARES = N_ANDARES_DEF,
    parameter int W_ANDAR   = W_ANDAR_DEF,
    parameter int ANDAR_RES = ANDAR_RES_DEF,
    parameter int T_VIAGEM  = T_VIAGEM_DEF,
    parameter int T_PORTA   = T_PORTA_DEF
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [N_ANDARES-1:0] botoes,
    input  logic                 cartao_acesso,
    input  logic                 sensor,
    input  logic                 segurar,
    output logic [N_ANDARES-1:0] pendentes,
    output logic [W_ANDAR-1:0]   andar_atual,
    output logic                 direcao,
    output logic                 movendo,
    output logic                 porta_aberta,
    output logic                 chegou
);

    localparam int W_VIAGEM = (T_VIAGEM > 1) ? $clog2(T_VIAGEM) : 1;
    localparam logic [W_VIAGEM-1:0]  VIAGEM_FIM   = W_VIAGEM'(T_VIAGEM - 1);
    localparam logic [W_VIAGEM-1:0]  VIAGEM_UM    = W_VIAGEM'(1);
    localparam logic [W_VIAGEM-1:0]  VIAGEM_ZERO  = {W_VIAGEM{1'b0}};
    localparam logic [W_ANDAR-1:0]   ANDAR_MAX    = W_ANDAR'(N_ANDARES - 1);
    localparam logic [W_ANDAR-1:0]   ANDAR_MIN    = {W_ANDAR{1'b0}};
    localparam logic [W_ANDAR-1:0]   ANDAR_UM     = W_ANDAR'(1);
    localparam logic [N_ANDARES-1:0] SEM_CHAMADAS = {N_ANDARES{1'b0}};

    estado_t               r_estado;
    logic [N_ANDARES-1:0]  r_pend;
    logic [W_ANDAR-1:0]    r_andar;
    logic                  r_dir;
    logic                  r_movendo;
    logic                  r_porta;
    logic                  r_chegou;
    logic [W_VIAGEM-1:0]   r_viagem;
    // Calls register was empty one edge ago: every current call arrived together
    logic                  r_ocioso;

    logic [N_ANDARES-1:0]  w_qual;
    logic [N_ANDARES-1:0]  w_limpa;
    logic [N_ANDARES-1:0]  w_pend_prox;
    logic [W_ANDAR-1:0]    w_andar_cima;
    logic [W_ANDAR-1:0]    w_andar_baixo;
    logic                  w_acima;
    logic                  w_abaixo;
    logic                  w_acima_prox;
    logic                  w_abaixo_prox;
    logic                  w_pend_cima;
    logic                  w_pend_baixo;
    logic                  w_abre_aqui;
    logic                  w_segura;
    logic                  w_segura_porta;
    logic                  w_pode_subir;
    logic                  w_pode_descer;
    logic                  w_fim_viagem;
    logic                  w_carga;
    logic                  w_porta_expirou;

    // Presses qualified by the residential access card
    always_comb begin
        w_qual = SEM_CHAMADAS;
        for (int i = 0; i < N_ANDARES; i++) begin
            w_qual[i] = botoes[i] & ((i < ANDAR_RES) | cartao_acesso);
        end
    end

    assign w_andar_cima  = r_andar + ANDAR_UM;
    assign w_andar_baixo = r_andar - ANDAR_UM;
    assign w_pode_subir  = (r_andar != ANDAR_MAX);
    assign w_pode_descer = (r_andar != ANDAR_MIN);
    assign w_fim_viagem  = (r_viagem == VIAGEM_FIM);
    assign w_pend_cima   = r_pend[w_andar_cima];
    assign w_pend_baixo  = r_pend[w_andar_baixo];
    assign w_abre_aqui   = r_pend[r_andar] | w_qual[r_andar];
    assign w_segura      = sensor | segurar | w_qual[r_andar];
    assign w_segura_porta = (r_estado == PORTA_ABERTA) & w_segura;

    // Pending calls strictly above/below the current floor and beyond the neighbour floors
    always_comb begin
        w_acima       = 1'b0;
        w_abaixo      = 1'b0;
        w_acima_prox  = 1'b0;
        w_abaixo_prox = 1'b0;
        for (int i = 0; i < N_ANDARES; i++) begin
            w_acima       = w_acima       | (r_pend[i] & (W_ANDAR'(i) > r_andar));
            w_abaixo      = w_abaixo      | (r_pend[i] & (W_ANDAR'(i) < r_andar));
            w_acima_prox  = w_acima_prox  | (r_pend[i] & (W_ANDAR'(i) > w_andar_cima));
            w_abaixo_prox = w_abaixo_prox | (r_pend[i] & (W_ANDAR'(i) < w_andar_baixo));
        end
    end

    // Door-open request this edge and which call bit gets served
    always_comb begin
        w_carga = 1'b0;
        w_limpa = SEM_CHAMADAS;
        case (r_estado)
            PARADO: begin
                // a press at the current floor opens the door instead of latching
                w_carga          = w_abre_aqui;
                w_limpa[r_andar] = 1'b1;
            end
            SUBINDO: begin
                if (w_pode_subir && w_fim_viagem && w_pend_cima) begin
                    w_carga               = 1'b1;
                    w_limpa[w_andar_cima] = 1'b1;
                end else begin
                    w_carga = 1'b0;
                end
            end
            DESCENDO: begin
                if (w_pode_descer && w_fim_viagem && w_pend_baixo) begin
                    w_carga                = 1'b1;
                    w_limpa[w_andar_baixo] = 1'b1;
                end else begin
                    w_carga = 1'b0;
                end
            end
            PORTA_ABERTA: begin
                w_limpa[r_andar] = 1'b1;
            end
            default: begin
                w_carga = 1'b0;
            end
        endcase
    end

    assign w_pend_prox = (r_pend | w_qual) & ~w_limpa;

    temporizador_porta #(
        .T_PORTA (T_PORTA)
    ) u_temporizador_porta (
        .clock   (clock),
        .clear   (clear),
        .carga   (w_carga),
        .segura  (w_segura_porta),
        .expirou (w_porta_expirou)
    );

    // Trip FSM: call register, floor, direction, travel counter and status outputs
    always_ff @(posedge clock) begin
        if (clear) begin
            r_estado  <= PARADO;
            r_pend    <= SEM_CHAMADAS;
            r_andar   <= ANDAR_MIN;
            r_dir     <= DIR_SOBE;
            r_movendo <= 1'b0;
            r_porta   <= 1'b0;
            r_chegou  <= 1'b0;
            r_viagem  <= VIAGEM_ZERO;
            r_ocioso  <= 1'b1;
        end else begin
            r_pend   <= w_pend_prox;
            r_ocioso <= (r_pend == SEM_CHAMADAS);
            r_chegou <= 1'b0;
            case (r_estado)
                PARADO: begin
                    r_viagem <= VIAGEM_ZERO;
                    if (w_abre_aqui) begin
                        r_estado  <= PORTA_ABERTA;
                        r_porta   <= 1'b1;
                        r_movendo <= 1'b0;
                        r_chegou  <= 1'b1;
                    end else if (w_acima && ((r_dir == DIR_SOBE) || !w_abaixo || r_ocioso)) begin
                        // simultaneous first calls on both sides resolve upwards
                        r_estado  <= SUBINDO;
                        r_dir     <= DIR_SOBE;
                        r_movendo <= 1'b1;
                        r_porta   <= 1'b0;
                    end else if (w_abaixo) begin
                        r_estado  <= DESCENDO;
                        r_dir     <= DIR_DESCE;
                        r_movendo <= 1'b1;
                        r_porta   <= 1'b0;
                    end else begin
                        r_estado  <= PARADO;
                        r_movendo <= 1'b0;
                        r_porta   <= 1'b0;
                    end
                end
                SUBINDO: begin
                    if (!w_pode_subir) begin
                        r_estado  <= PARADO;
                        r_movendo <= 1'b0;
                        r_viagem  <= VIAGEM_ZERO;
                    end else if (!w_fim_viagem) begin
                        r_viagem <= r_viagem + VIAGEM_UM;
                    end else begin
                        r_viagem <= VIAGEM_ZERO;
                        r_andar  <= w_andar_cima;
                        if (w_pend_cima) begin
                            r_estado  <= PORTA_ABERTA;
                            r_porta   <= 1'b1;
                            r_movendo <= 1'b0;
                            r_chegou  <= 1'b1;
                        end else if (w_acima_prox) begin
                            r_estado <= SUBINDO;
                        end else begin
                            r_estado  <= PARADO;
                            r_movendo <= 1'b0;
                        end
                    end
                end
                DESCENDO: begin
                    if (!w_pode_descer) begin
                        r_estado  <= PARADO;
                        r_movendo <= 1'b0;
                        r_viagem  <= VIAGEM_ZERO;
                    end else if (!w_fim_viagem) begin
                        r_viagem <= r_viagem + VIAGEM_UM;
                    end else begin
                        r_viagem <= VIAGEM_ZERO;
                        r_andar  <= w_andar_baixo;
                        if (w_pend_baixo) begin
                            r_estado  <= PORTA_ABERTA;
                            r_porta   <= 1'b1;
                            r_movendo <= 1'b0;
                            r_chegou  <= 1'b1;
                        end else if (w_abaixo_prox) begin
                            r_estado <= DESCENDO;
                        end else begin
                            r_estado  <= PARADO;
                            r_movendo <= 1'b0;
                        end
                    end
                end
                PORTA_ABERTA: begin
                    r_viagem <= VIAGEM_ZERO;
                    if (w_segura) begin
                        r_estado <= PORTA_ABERTA;
                    end else if (w_porta_expirou) begin
                        r_estado <= PARADO;
                        r_porta  <= 1'b0;
                    end else begin
                        r_estado <= PORTA_ABERTA;
                    end
                end
                default: begin
                    r_estado  <= PARADO;
                    r_movendo <= 1'b0;
                    r_porta   <= 1'b0;
                    r_viagem  <= VIAGEM_ZERO;
                end
            endcase
        end
    end

    assign pendentes    = r_pend;
    assign andar_atual  = r_andar;
    assign direcao      = r_dir;
    assign movendo      = r_movendo;
    assign porta_aberta = r_porta;
    assign chegou       = r_chegou;

endmodule

// File: tb/tb_escalonador_elevador.sv
module tb_escalonador_elevador;

    localparam int N   = 16;
    localparam int W   = 4;
    localparam int RES = 6;
    localparam int TV  = 1;
    localparam int TP  = 4;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic         clock = 1'b0;
    logic         clear;
    logic [N-1:0] botoes;
    logic         cartao_acesso;
    logic         sensor;
    logic         segurar;
    logic [N-1:0] pendentes;
    logic [W-1:0] andar_atual;
    logic         direcao;
    logic         movendo;
    logic         porta_aberta;
    logic         chegou;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    escalonador_elevador #(
        .N_ANDARES (N),
        .W_ANDAR   (W),
        .ANDAR_RES (RES),
        .T_VIAGEM  (TV),
        .T_PORTA   (TP)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .botoes        (botoes),
        .cartao_acesso (cartao_acesso),
        .sensor        (sensor),
        .segurar       (segurar),
        .pendentes     (pendentes),
        .andar_atual   (andar_atual),
        .direcao       (direcao),
        .movendo       (movendo),
        .porta_aberta  (porta_aberta),
        .chegou        (chegou)
    );

    // Behavioural model of the elevator: what the cabin is doing, where, and the call set
    typedef struct packed {
        int         floor;
        bit         dir;
        bit [N-1:0] pend;
        int         mode;
        int         travel;   // edges left until the next floor
        int         door;     // open cycles left without a hold
        bit         arrive;
        bit         fresh;    // no calls were waiting one edge ago
        bit         valid;
    } model_t;

    model_t m = '0;

    function automatic bit calls_beyond(input bit [N-1:0] p, input int f, input bit up);
        for (int i = 0; i < N; i++) begin
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic model_t model_next(input model_t s, input logic rst, input logic [N-1:0] b,
                                          input logic card, input logic hold);
        model_t     n;
        bit [N-1:0] press;
        bit         up;
        bit         dn;
        int         nf;
        n = s;
        if (rst) begin
            n.floor = 0; n.dir = 1'b1; n.pend = '0; n.mode = M_IDLE;
            n.travel = 0; n.door = 0; n.arrive = 1'b0; n.fresh = 1'b1; n.valid = 1'b1;
            return n;
        end
        press = '0;
        for (int i = 0; i < N; i++) press[i] = b[i] && ((i < RES) || card);
        n.arrive = 1'b0;
        n.fresh  = (s.pend == '0);
        n.pend   = s.pend | press;
        case (s.mode)
            M_IDLE: begin
                n.pend[s.floor] = 1'b0;
                if (s.pend[s.floor] || press[s.floor]) begin
                    n.mode = M_DOOR; n.door = TP; n.arrive = 1'b1;
                end else begin
                    up = calls_beyond(s.pend, s.floor, 1'b1);
                    dn = calls_beyond(s.pend, s.floor, 1'b0);
                    if (up && (s.dir || !dn || s.fresh)) begin
                        n.mode = M_MOVE; n.dir = 1'b1; n.travel = TV;
                    end else if (dn) begin
                        n.mode = M_MOVE; n.dir = 1'b0; n.travel = TV;
                    end
                end
            end
            M_MOVE: begin
                if ((s.dir && s.floor == N - 1) || (!s.dir && s.floor == 0)) begin
                    n.mode = M_IDLE;
                end else begin
                    n.travel = s.travel - 1;
                    if (n.travel == 0) begin
                        nf = s.dir ? s.floor + 1 : s.floor - 1;
                        n.floor = nf;
                        if (s.pend[nf]) begin
                            n.pend[nf] = 1'b0; n.mode = M_DOOR; n.door = TP; n.arrive = 1'b1;
                        end else if (calls_beyond(s.pend, nf, s.dir)) begin
                            n.travel = TV;
                        end else begin
                            n.mode = M_IDLE;
                        end
                    end
                end
            end
            M_DOOR: begin
                n.pend[s.floor] = 1'b0;
                if (hold || press[s.floor]) begin
                    n.door = TP;
                end else begin
                    n.door = s.door - 1;
                    if (n.door == 0) n.mode = M_IDLE;
                end
            end
            default: n.mode = M_IDLE;
        endcase
        return n;
    endfunction

    always @(posedge clock) begin
        m <= model_next(m, clear, botoes, cartao_acesso, sensor | segurar);
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (m.valid) begin
            checks++;
            if (pendentes !== m.pend || andar_atual !== 4'(m.floor) || direcao !== m.dir ||
                movendo !== (m.mode == M_MOVE) || porta_aberta !== (m.mode == M_DOOR) || chegou !== m.arrive) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got pend=%h floor=%0d dir=%b mov=%b door=%b arr=%b, expected pend=%h floor=%0d dir=%b mov=%b door=%b arr=%b",
                         $time, pendentes, andar_atual, direcao, movendo, porta_aberta, chegou,
                         m.pend, m.floor, m.dir, (m.mode == M_MOVE), (m.mode == M_DOOR), m.arrive);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_arrival(input string name);
        int n;
        n = 0;
        while (chegou !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk(name, {31'd0, chegou}, 32'd1);
    endtask

    task automatic wait_closed(input string name);
        int n;
        n = 0;
        while (porta_aberta !== 1'b0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk(name, {31'd0, porta_aberta}, 32'd0);
    endtask

    task automatic press(input logic [N-1:0] b, input logic card);
        botoes = b;
        cartao_acesso = card;
        @(negedge clock);
        botoes = '0;
        cartao_acesso = 1'b0;
    endtask

    initial begin
        int n;
        clear = 1'b1; botoes = '0; cartao_acesso = 1'b0; sensor = 1'b0; segurar = 1'b0;
        repeat (2) @(negedge clock);
        clear = 1'b0;
        chk("rst_floor", andar_atual, 0);
        chk("rst_pend", pendentes, 0);
        chk("rst_dir", direcao, 1);
        chk("rst_door", porta_aberta, 0);
        chk("rst_mov", movendo, 0);

        // Trip 0 -> 3: latch at k, move at k+1, floors at k+2..k+4
        @(negedge clock);
        press(16'h0008, 1'b0);
        chk("k_latch3", pendentes, 16'h0008);
        chk("k_floor0", andar_atual, 0);
        @(negedge clock);
        chk("k1_moving", movendo, 1);
        chk("k1_floor0", andar_atual, 0);
        @(negedge clock); chk("k2_floor1", andar_atual, 1);
        @(negedge clock); chk("k3_floor2", andar_atual, 2);
        @(negedge clock);
        chk("k4_floor3", andar_atual, 3);
        chk("k4_door", porta_aberta, 1);
        chk("k4_chegou", chegou, 1);
        chk("k4_pend_clr", pendentes, 0);
        n = 0;
        while (porta_aberta === 1'b1 && n < 20) begin n++; @(negedge clock); end
        chk("door_cycles_3", n, TP);
        chk("idle_after_3", movendo, 0);

        // Residential floor needs the card in the same cycle
        press(16'h0200, 1'b0);
        repeat (2) @(negedge clock);
        chk("nocard_pend", pendentes, 0);
        chk("nocard_still", movendo, 0);
        press(16'h0200, 1'b1);
        chk("card_pend9", pendentes, 16'h0200);
        wait_arrival("arrive_9");
        chk("floor_9", andar_atual, 9);
        wait_closed("close_9");

        // Down to 5, then simultaneous calls at 2 and 10 go up first
        press(16'h0020, 1'b0);
        wait_arrival("arrive_5");
        chk("floor_5", andar_atual, 5);
        chk("dir_down_5", direcao, 0);
        wait_closed("close_5");
        press(16'h0404, 1'b1);
        chk("pend_2_10", pendentes, 16'h0404);
        @(negedge clock);
        chk("tie_goes_up", direcao, 1);
        wait_arrival("arrive_10");
        chk("floor_10", andar_atual, 10);
        chk("pend_2_left", pendentes, 16'h0004);
        wait_closed("close_10");
        wait_arrival("arrive_2");
        chk("floor_2", andar_atual, 2);
        chk("dir_down_2", direcao, 0);
        wait_closed("close_2");

        // Door at 4 held by the sensor for 10 cycles
        press(16'h0010, 1'b0);
        wait_arrival("arrive_4");
        n = 1;
        sensor = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (porta_aberta === 1'b1) n++;
        end
        sensor = 1'b0;
        while (porta_aberta === 1'b1 && n < 40) begin
            @(negedge clock);
            if (porta_aberta === 1'b1) n++;
        end
        chk("held_door_cycles", n, 10 + TP);
        chk("held_floor_4", andar_atual, 4);

        // Back to 0, then 0 -> 8 with a call at 5 picked up at floor 2
        press(16'h0001, 1'b0);
        wait_arrival("arrive_0");
        chk("floor_0", andar_atual, 0);
        wait_closed("close_0");
        press(16'h0100, 1'b1);
        n = 0;
        while (andar_atual !== 4'd2 && n < 30) begin @(negedge clock); n++; end
        chk("reach_2", andar_atual, 2);
        press(16'h0020, 1'b0);
        wait_arrival("arrive_5_sweep");
        chk("stop_5", andar_atual, 5);
        wait_closed("close_5b");
        wait_arrival("arrive_8");
        chk("stop_8", andar_atual, 8);
        wait_closed("close_8");

        // Clear at floor 7 with the door open and a call pending
        press(16'h0080, 1'b1);
        wait_arrival("arrive_7");
        chk("floor_7", andar_atual, 7);
        press(16'h0002, 1'b0);
        chk("pend_1_held", pendentes, 16'h0002);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clr_floor", andar_atual, 0);
        chk("clr_pend", pendentes, 0);
        chk("clr_door", porta_aberta, 0);
        chk("clr_dir", direcao, 1);
        chk("clr_mov", movendo, 0);
        chk("clr_chegou", chegou, 0);
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/escalonador_elevador.md
Name: escalonador_elevador

Overview:
- Central trip controller for the 16-floor elevator (floors 0-15; 0-5 commercial, 6-15 residential).
- Latches cabin/landing calls, enforces the residential access card, and runs a SCAN direction policy.
- Moves the cabin one floor per T_VIAGEM cycles, stops at pending floors, clears served calls and times the door.
- Sits between the button/card inputs and the floor-display/LED logic; owns the floor register and the door state.

Parameters:
- N_ANDARES, 16, number of floors; one call bit per floor.
- W_ANDAR, 4, floor index width, equal to clog2(N_ANDARES).
- ANDAR_RES, 6, lowest residential floor; floors at or above it need cartao_acesso.
- T_VIAGEM, 1, cycles to travel one floor; must be 1 or more.
- T_PORTA, 4, cycles the door stays open after the last hold; must be 1 or more.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- botoes  in  N_ANDARES  call buttons, level, sampled every cycle.
- cartao_acesso  in  1  residential pass present; qualifies same-cycle botoes bits at or above ANDAR_RES.
- sensor  in  1  door presence sensor; holds door open.
- segurar  in  1  hold-door button; holds door open.
- pendentes  out  N_ANDARES  latched calls; drives button LEDs.
- andar_atual  out  W_ANDAR  current floor.
- direcao  out  1  1 = up, 0 = down; last or active direction.
- movendo  out  1  high in SUBINDO or DESCENDO.
- porta_aberta  out  1  high in PORTA_ABERTA.
- chegou  out  1  one-cycle pulse on the edge the cabin stops at a served floor.

Behaviour:
- clear, sampled at the edge, has priority over everything.
  - Outputs after clear: pendentes=0, andar_atual=0, direcao=1, movendo=0, porta_aberta=0, chegou=0.
  - Internal state after clear: FSM=PARADO, both timers=0.
  - Assertion mid-move or with the door open abandons the trip; the floor returns to 0.
- Call latch:
  - Per edge, pendentes[i] is set by botoes[i] & (i<ANDAR_RES | cartao_acesso).
  - A bit is cleared only when its floor is served.
  - A residential press without the card is ignored; the card must be present in the same cycle.
  - A press at andar_atual while PARADO or PORTA_ABERTA is not latched; it opens or reopens the door instead.
- FSM states: PARADO, SUBINDO, DESCENDO, PORTA_ABERTA.
- PARADO (evaluates registered pendentes):
  - Open-door request at the current floor: next state PORTA_ABERTA, door timer loaded with T_PORTA, chegou=1.
  - Otherwise, calls exist above and direcao=1 (or no calls below): SUBINDO, direcao=1.
  - Otherwise, calls exist below: DESCENDO, direcao=0.
  - Idle arrivals: the first call to arrive sets the direction (SCAN tie-break). Simultaneous first calls above and below go up.
  - No calls: remain in PARADO.
- SUBINDO / DESCENDO:
  - Travel counter counts T_VIAGEM cycles, then andar_atual increments or decrements on that edge.
  - If the new floor is pending: state PORTA_ABERTA on the same edge, bit cleared, chegou=1, door timer = T_PORTA.
  - If not pending and calls remain ahead: continue.
  - If not pending and nothing is ahead (calls cannot vanish except by clear): go to PARADO.
  - andar_atual never passes 0 or N_ANDARES-1; a move at the limit is suppressed and the state returns to PARADO.
- PORTA_ABERTA:
  - Timer decrements each cycle.
  - sensor, segurar, or a press at the current floor reloads the timer to T_PORTA.
  - At 0 with no hold: go to PARADO. The door is open exactly T_PORTA cycles when there is no hold.
- Calls arriving during motion are latched normally and served on this sweep if ahead, otherwise on the reverse sweep.
- Latency example, T_VIAGEM=1: press at edge k latches at k. Edge k+1 enters SUBINDO. Each following edge moves one floor.

Decomposition:
- Package elevador_pkg:
  - state enum {PARADO, SUBINDO, DESCENDO, PORTA_ABERTA}.
  - Constants DIR_SOBE=1, DIR_DESCE=0.
  - Defaults for ANDAR_RES, N_ANDARES, W_ANDAR.
- One sub-module, temporizador_porta: loadable down-counter with inputs carga and segura, and output expirou.
- Above/below call masks are computed inline as combinational compares against andar_atual.

Test Plan:
- Reset at floor 7 with the door open -> next cycle andar_atual=0, pendentes=0, porta_aberta=0, direcao=1.
- At floor 0, press botoes[3] (T_VIAGEM=1) at edge k -> floor 1,2,3 at edges k+2..k+4. porta_aberta=1 and chegou=1 at k+4, pendentes[3]=0, door open 4 cycles, then PARADO.
- Press botoes[9] with cartao_acesso=0 -> pendentes stays 0, no motion. Repeat with cartao_acesso=1 -> pendentes[9]=1 and the cabin travels to 9.
- At floor 5 idle, botoes[2] and botoes[10] in the same cycle (card present) -> goes up, stops at 10, then reverses and stops at 2.
- Door open at floor 4, sensor held 10 cycles then released -> porta_aberta stays 1 for 10 + T_PORTA cycles, with no motion during that time.
- While SUBINDO from 0 toward 8, press botoes[5] at floor 2 -> stops at 5 (chegou pulse), then continues to 8.
